// File: rtl/axi_write_responder_if.sv
// Bundle of the AW/W/B channels plus the registered write-sink port of the AXI write responder.
// The slave modport is the responder's view; the master modport is the requesting side's view.
interface axi_write_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic                      aw_valid_i;
    logic                      aw_ready_o;
    logic [ID_WIDTH-1:0]       aw_id_i;
    logic [7:0]                aw_len_i;

    logic                      w_valid_i;
    logic                      w_ready_o;
    logic [DATA_WIDTH-1:0]     w_data_i;
    logic [DATA_WIDTH/8-1:0]   w_strb_i;
    logic                      w_last_i;

    logic                      b_valid_o;
    logic                      b_ready_i;
    logic [ID_WIDTH-1:0]       b_id_o;
    logic [1:0]                b_resp_o;

    logic                      wr_en_o;
    logic [DATA_WIDTH-1:0]     wr_data_o;
    logic [DATA_WIDTH/8-1:0]   wr_strb_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_len_i,
        input  w_valid_i, w_data_i, w_strb_i, w_last_i,
        input  b_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        output wr_en_o, wr_data_o, wr_strb_o
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_len_i,
        output w_valid_i, w_data_i, w_strb_i, w_last_i,
        output b_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        input  wr_en_o, wr_data_o, wr_strb_o
    );
endinterface

// File: rtl/axi_write_responder.sv
// AXI write-path terminator: queues AW requests, consumes the matching W beats into a
// registered write sink and returns one B response per burst (SLVERR on a WLAST mismatch).
module axi_write_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int AW_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi_write_responder_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
    localparam int CNT_W      = $clog2(AW_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [ID_WIDTH-1:0]   q_id  [AW_DEPTH];
    logic [7:0]            q_len [AW_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  aw_ready_q;
    logic                  push;
    logic                  pop;
    logic [ID_WIDTH-1:0]   head_id;
    logic [7:0]            head_len;

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            cnt_q;
    logic                  err_q;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [1:0]            b_resp_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;

    logic                  w_ready;
    logic                  b_valid;
    logic                  load_burst;
    logic                  beat_acc;
    logic                  final_beat;
    logic                  mismatch;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(AW_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign push     = bus.aw_valid_i & aw_ready_q;
    assign head_id  = q_id[rd_ptr_q];
    assign head_len = q_len[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // aw_ready is registered from the next occupancy, so a pop never reaches it combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            aw_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q    <= count_d;
            aw_ready_q <= (count_d != CNT_W'(AW_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_id[wr_ptr_q]  <= bus.aw_id_i;
            q_len[wr_ptr_q] <= bus.aw_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A beat closes the burst when the counter runs out or WLAST arrives, whichever is first.
    always_comb begin
        state_d    = state_q;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        pop        = 1'b0;
        load_burst = 1'b0;
        beat_acc   = 1'b0;
        final_beat = 1'b0;
        mismatch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load_burst = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                w_ready = 1'b1;
                if (bus.w_valid_i) begin
                    beat_acc   = 1'b1;
                    final_beat = (cnt_q == 8'd0) || bus.w_last_i;
                    mismatch   = (cnt_q == 8'd0) != bus.w_last_i;
                    if (final_beat) begin
                        pop     = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                b_valid = 1'b1;
                if (bus.b_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            b_id_q   <= '0;
            b_resp_q <= 2'b00;
        end else begin
            if (load_burst) begin
                cnt_q <= head_len;
                err_q <= 1'b0;
            end else if (beat_acc) begin
                if (final_beat) begin
                    b_id_q   <= head_id;
                    b_resp_q <= (err_q || mismatch) ? 2'b10 : 2'b00;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                    err_q <= err_q | mismatch;
                end
            end
        end
    end

    // Sink data/strobes keep the last accepted beat; only the enable pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            wr_en_q <= beat_acc;
            if (beat_acc) begin
                wr_data_q <= bus.w_data_i;
                wr_strb_q <= bus.w_strb_i;
            end
        end
    end

    assign bus.aw_ready_o = aw_ready_q;
    assign bus.w_ready_o  = w_ready;
    assign bus.b_valid_o  = b_valid;
    assign bus.b_id_o     = b_id_q;
    assign bus.b_resp_o   = b_resp_q;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.wr_strb_o  = wr_strb_q;
endmodule

// File: doc/axi_write_responder.md
Name: axi_write_responder

Overview:
Slave-side terminator for the AXI write path. It accepts AW requests into a small queue and consumes the matching W beats, forwarding each beat to a simple registered write-sink port. It returns one B response per burst with the request's ID. It is the responder end for masters driven through the team's AXI channel slices; it is used for memory stubs, scratchpads and error slaves.

Parameters:
ID_WIDTH, 4, width of aw_id_i / b_id_o
DATA_WIDTH, 64, W data width; strobe width is DATA_WIDTH/8
AW_DEPTH, 4, AW queue entries (>=1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-high
aw_valid_i  in  1  AW valid
aw_ready_o  out  1  AW ready, equals ~queue_full
aw_id_i  in  ID_WIDTH  AW ID
aw_len_i  in  8  AW burst length minus one
w_valid_i  in  1  W valid
w_ready_o  out  1  W ready
w_data_i  in  DATA_WIDTH  W data
w_strb_i  in  DATA_WIDTH/8  W strobes
w_last_i  in  1  W last
b_valid_o  out  1  B valid
b_ready_i  in  1  B ready
b_id_o  out  ID_WIDTH  B ID
b_resp_o  out  2  B response: 2'b00 OKAY, 2'b10 SLVERR
wr_en_o  out  1  registered write strobe, one cycle per accepted W beat
wr_data_o  out  DATA_WIDTH  registered beat data
wr_strb_o  out  DATA_WIDTH/8  registered beat strobes

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- While rst_i is high:
  - All outputs are 0, including aw_ready_o.
  - The queue is empty, the FSM is in IDLE and the beat counter is 0.
- Reset asserted mid-burst discards all queued AW entries and any pending B response; no B is issued for them.
- AW queue:
  - Non-fall-through FIFO of {id, len}.
  - Push on aw_valid_i & aw_ready_o; pop on completion of a burst.
  - An entry pushed in cycle N is visible to the FSM at cycle N+1 at the earliest.
  - A push and a pop in the same cycle while full is allowed only if aw_ready_o was already high; aw_ready_o is ~full from registered state, with no combinational path from the pop.
- FSM states:
  - IDLE: w_ready_o=0, b_valid_o=0. If the queue is non-empty, load cnt<=head.len and err<=0, then go to DATA.
  - DATA: w_ready_o=1. On each accepted beat (w_valid_i & w_ready_o):
    - The beat is final if cnt==0 or w_last_i==1.
    - A mismatch, (cnt==0) != w_last_i, sets err.
    - If the beat is not final, decrement cnt.
    - If the beat is final: pop the queue, load b_id_o<=head.id, load b_resp_o<= (err or mismatch on this beat) ? 2'b10 : 2'b00, then go to RESP.
  - RESP: b_valid_o=1. b_id_o and b_resp_o are held stable until b_ready_i. On b_valid_o & b_ready_i, go to IDLE.
- Burst termination:
  - A burst ends at the first of "len+1 beats" or "w_last_i".
  - An early w_last_i gives SLVERR with a short burst.
  - A missing w_last_i on beat len+1 gives SLVERR; subsequent beats belong to the next queued burst.
- Latency:
  - b_valid_o rises the cycle after the final W beat is accepted.
  - There is one IDLE bubble cycle between bursts.
  - Best case per burst: len+3 cycles with b_ready_i tied high.
- Write-sink port: wr_en_o/wr_data_o/wr_strb_o register the accepted beat one cycle after acceptance. wr_en_o is deasserted otherwise; wr_data_o and wr_strb_o hold their last value.
- W beats arriving with an empty queue are stalled (w_ready_o=0); they are never dropped or accepted.
- AW is accepted independently of W/B progress whenever the queue is not full.
- Strobes are passed through unmodified; an all-zero strobe is still a counted beat.

Test Plan:
1. Reset, then hold aw_valid_i=0, w_valid_i=0 -> all outputs 0 during reset. After reset: aw_ready_o=1, w_ready_o=0, b_valid_o=0.
2. Single burst:
   - Stimulus: AW id=3, len=3. Then 4 W beats with data 0x10..0x13 and w_last_i on beat 4. b_ready_i=1.
   - Response: wr_en_o pulses 4 times with data 0x10..0x13. One B with id=3, resp=00, asserted the cycle after beat 4.
3. Back-to-back AW:
   - Stimulus: AW id=1..5, len=0, with no W activity.
   - Response: aw_ready_o drops after 4 accepts with AW_DEPTH=4. Then send 5 single-beat W with w_last_i=1 -> B ids 1,2,3,4,5 in order, all OKAY.
4. Early last: AW id=7, len=3, w_last_i on beat 2 -> B id=7, resp=10 after beat 2. The next W beat stalls until the next AW is queued.
5. Missing last: AW id=2, len=1 and AW id=4, len=0. Send 3 beats with w_last_i only on beat 3 -> B id=2 resp=10, then B id=4 resp=00.
6. B backpressure and reset:
   - b_ready_i=0 for 10 cycles -> b_valid_o, b_id_o and b_resp_o are stable, w_ready_o=0.
   - Assert rst_i while in RESP with 2 entries queued -> B dropped, queue empty, no further B after release.
